// File: rtl/board_display.sv
`default_nettype none
// ============================================================================
// Module   : board_display
// Purpose  : Display back end of the game. Turns the board state, turn flags
//            and game status from the game core into board LEDs, turn LEDs
//            and a scanned 4-digit 7-segment display.
//              - X squares are lit steady; O squares flash with flash_ph.
//              - A terminal game_st is shown as a letter on digit 0.
//              - 'E' flashes the whole board.
//            All outputs are registered in the single clk domain.
// Ports    : clk        in   system clock, rising edge
//            reset      in   synchronous active-high reset
//            occ_pos    in 9 square occupied (bit i = square i, row-major)
//            own_o      in 9 occupant is O (1) or X (0)
//            turnX      in   X to move
//            turnO      in   O to move
//            game_st    in 8 ASCII 'X'/'O'/'C'/'E' terminal, else in play
//            led        out 9 board LEDs, active-high
//            led_turnX  out  X turn LED
//            led_turnO  out  O turn LED
//            seg        out 7 segments {g,f,e,d,c,b,a}, active-low
//            an         out 4 digit enables, active-low, an[0] rightmost
// Revision : 1.0 - initial release
// ============================================================================
module board_display #(
  parameter int FLASH_DIV = 25_000_000,
  parameter int SCAN_DIV  = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] occ_pos,
  input  logic [8:0] own_o,
  input  logic       turnX,
  input  logic       turnO,
  input  logic [7:0] game_st,
  output logic [8:0] led,
  output logic       led_turnX,
  output logic       led_turnO,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int FW = $clog2(FLASH_DIV);
  localparam int SW = $clog2(SCAN_DIV);

  localparam logic [7:0] c_ASC_X = 8'h58;
  localparam logic [7:0] c_ASC_O = 8'h4F;
  localparam logic [7:0] c_ASC_C = 8'h43;
  localparam logic [7:0] c_ASC_E = 8'h45;

  localparam logic [6:0] c_GLY_X     = 7'h09;
  localparam logic [6:0] c_GLY_O     = 7'h40;
  localparam logic [6:0] c_GLY_C     = 7'h46;
  localparam logic [6:0] c_GLY_E     = 7'h06;
  localparam logic [6:0] c_GLY_DASH  = 7'h3F;
  localparam logic [6:0] c_GLY_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    OVER  = 2'd1,
    ERROR = 2'd2
  } mode_t;

  mode_t         r_mode;
  logic [FW-1:0] r_flash_cnt;
  logic          r_flash_ph;
  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_digit;

  mode_t         w_mode_nxt;
  logic [FW-1:0] w_flash_cnt_nxt;
  logic          w_flash_ph_nxt;
  logic [SW-1:0] w_scan_cnt_nxt;
  logic [1:0]    w_digit_nxt;
  logic          w_is_over;
  logic          w_is_err;
  logic [6:0]    w_st_glyph;
  logic [6:0]    w_mover_glyph;
  logic [8:0]    w_led_nxt;
  logic          w_tx_nxt;
  logic          w_to_nxt;
  logic [6:0]    w_seg_nxt;
  logic [3:0]    w_an_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode      <= PLAY;
      r_flash_cnt <= '0;
      r_flash_ph  <= 1'b0;
      r_scan_cnt  <= '0;
      r_digit     <= 2'd0;
      led         <= 9'h000;
      led_turnX   <= 1'b0;
      led_turnO   <= 1'b0;
      seg         <= c_GLY_BLANK;
      an          <= 4'hF;
    end else begin
      r_mode      <= w_mode_nxt;
      r_flash_cnt <= w_flash_cnt_nxt;
      r_flash_ph  <= w_flash_ph_nxt;
      r_scan_cnt  <= w_scan_cnt_nxt;
      r_digit     <= w_digit_nxt;
      led         <= w_led_nxt;
      led_turnX   <= w_tx_nxt;
      led_turnO   <= w_to_nxt;
      seg         <= w_seg_nxt;
      an          <= w_an_nxt;
    end
  end

  // Outputs are built from the next-state values so that mode, flash phase
  // and digit slot all become visible on the same edge that updates them.
  always_comb begin
    w_flash_cnt_nxt = r_flash_cnt + FW'(1);
    w_flash_ph_nxt  = r_flash_ph;
    if (r_flash_cnt == FW'(FLASH_DIV - 1)) begin
      w_flash_cnt_nxt = '0;
      w_flash_ph_nxt  = ~r_flash_ph;
    end

    w_scan_cnt_nxt = r_scan_cnt + SW'(1);
    w_digit_nxt    = r_digit;
    if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
      w_scan_cnt_nxt = '0;
      w_digit_nxt    = r_digit + 2'd1;
    end

    w_is_err  = (game_st == c_ASC_E);
    w_is_over = (game_st == c_ASC_X) || (game_st == c_ASC_O) || (game_st == c_ASC_C);

    w_mode_nxt = r_mode;
    case (r_mode)
      PLAY:    if (w_is_err) w_mode_nxt = ERROR; else if (w_is_over) w_mode_nxt = OVER;
      OVER:    if (w_is_err) w_mode_nxt = ERROR; else if (!w_is_over) w_mode_nxt = PLAY;
      ERROR:   if (w_is_over) w_mode_nxt = OVER; else if (!w_is_err) w_mode_nxt = PLAY;
      default: w_mode_nxt = PLAY;
    endcase

    case (game_st)
      c_ASC_X: w_st_glyph = c_GLY_X;
      c_ASC_O: w_st_glyph = c_GLY_O;
      c_ASC_C: w_st_glyph = c_GLY_C;
      c_ASC_E: w_st_glyph = c_GLY_E;
      default: w_st_glyph = c_GLY_BLANK;
    endcase

    case ({turnX, turnO})
      2'b10:   w_mover_glyph = c_GLY_X;
      2'b01:   w_mover_glyph = c_GLY_O;
      default: w_mover_glyph = c_GLY_DASH;
    endcase

    if (w_mode_nxt == ERROR)
      w_led_nxt = {9{w_flash_ph_nxt}};
    else
      w_led_nxt = occ_pos & (~own_o | {9{w_flash_ph_nxt}});

    w_tx_nxt = 1'b0;
    w_to_nxt = 1'b0;
    if (w_mode_nxt == PLAY) begin
      if (turnX && turnO) begin
        // Contradictory turn flags: flag the fault by flashing both.
        w_tx_nxt = w_flash_ph_nxt;
        w_to_nxt = w_flash_ph_nxt;
      end else begin
        w_tx_nxt = turnX;
        w_to_nxt = turnO;
      end
    end

    w_seg_nxt = c_GLY_BLANK;
    case (w_digit_nxt)
      2'd0:    if (w_mode_nxt != PLAY) w_seg_nxt = w_st_glyph;
      2'd3:    if (w_mode_nxt == PLAY) w_seg_nxt = w_mover_glyph;
      default: w_seg_nxt = c_GLY_BLANK;
    endcase

    w_an_nxt = ~(4'b0001 << w_digit_nxt);
  end

endmodule
`default_nettype wire

// File: tb/tb_board_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_display
// Purpose  : Self-checking bench for board_display with FLASH_DIV=4 and
//            SCAN_DIV=2. After reset release, N edges give
//            flash_ph = (N/4)%2 and digit = (N/2)%4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] occ_pos;
  logic [8:0] own_o;
  logic       turnX;
  logic       turnO;
  logic [7:0] game_st;
  logic [8:0] led;
  logic       led_turnX;
  logic       led_turnO;
  logic [6:0] seg;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  board_display #(.FLASH_DIV(4), .SCAN_DIV(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .occ_pos   (occ_pos),
    .own_o     (own_o),
    .turnX     (turnX),
    .turnO     (turnO),
    .game_st   (game_st),
    .led       (led),
    .led_turnX (led_turnX),
    .led_turnO (led_turnO),
    .seg       (seg),
    .an        (an)
  );

  typedef struct {
    logic [8:0] occ;
    logic [8:0] own;
    logic       tx;
    logic       to;
    logic [7:0] gst;
    int         n;
    logic [8:0] eled;
    logic       etx;
    logic       eto;
    logic [6:0] eseg;
    logic [3:0] ean;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [8:0] el, input logic etx,
                           input logic eto, input logic [6:0] es, input logic [3:0] ea);
    check({tag, ".led"}, 32'(led), 32'(el));
    check({tag, ".turnX"}, 32'(led_turnX), 32'(etx));
    check({tag, ".turnO"}, 32'(led_turnO), 32'(eto));
    check({tag, ".seg"}, 32'(seg), 32'(es));
    check({tag, ".an"}, 32'(an), 32'(ea));
  endtask

  task automatic check_reset(input string tag);
    check_all(tag, 9'h000, 1'b0, 1'b0, 7'h7F, 4'hF);
  endtask

  initial begin
    //                occ     own     tx    to    gst    n   led     tX    tO    seg    an
    vecs.push_back('{9'h003, 9'h002, 1'b0, 1'b0, 8'h00, 1, 9'h001, 1'b0, 1'b0, 7'h7F, 4'hE});
    vecs.push_back('{9'h003, 9'h002, 1'b0, 1'b0, 8'h00, 4, 9'h003, 1'b0, 1'b0, 7'h7F, 4'hB});
    vecs.push_back('{9'h003, 9'h002, 1'b0, 1'b0, 8'h00, 8, 9'h001, 1'b0, 1'b0, 7'h7F, 4'hE});
    vecs.push_back('{9'h000, 9'h000, 1'b1, 1'b0, 8'h00, 6, 9'h000, 1'b1, 1'b0, 7'h09, 4'h7});
    vecs.push_back('{9'h000, 9'h000, 1'b0, 1'b1, 8'h00, 7, 9'h000, 1'b0, 1'b1, 7'h40, 4'h7});
    vecs.push_back('{9'h000, 9'h000, 1'b1, 1'b1, 8'h00, 6, 9'h000, 1'b1, 1'b1, 7'h3F, 4'h7});
    vecs.push_back('{9'h000, 9'h000, 1'b1, 1'b1, 8'h00, 2, 9'h000, 1'b0, 1'b0, 7'h7F, 4'hD});
    vecs.push_back('{9'h000, 9'h000, 1'b0, 1'b0, 8'h00, 6, 9'h000, 1'b0, 1'b0, 7'h3F, 4'h7});
    vecs.push_back('{9'h003, 9'h002, 1'b1, 1'b0, 8'h43, 1, 9'h001, 1'b0, 1'b0, 7'h46, 4'hE});
    vecs.push_back('{9'h003, 9'h002, 1'b0, 1'b1, 8'h58, 8, 9'h001, 1'b0, 1'b0, 7'h09, 4'hE});
    vecs.push_back('{9'h000, 9'h000, 1'b0, 1'b0, 8'h4F, 9, 9'h000, 1'b0, 1'b0, 7'h40, 4'hE});
    vecs.push_back('{9'h000, 9'h000, 1'b0, 1'b0, 8'h4F, 2, 9'h000, 1'b0, 1'b0, 7'h7F, 4'hD});
    vecs.push_back('{9'h000, 9'h000, 1'b0, 1'b0, 8'h45, 4, 9'h1FF, 1'b0, 1'b0, 7'h7F, 4'hB});
    vecs.push_back('{9'h1FF, 9'h000, 1'b0, 1'b0, 8'h45, 8, 9'h000, 1'b0, 1'b0, 7'h06, 4'hE});
    vecs.push_back('{9'h000, 9'h1FF, 1'b0, 1'b0, 8'h00, 4, 9'h000, 1'b0, 1'b0, 7'h7F, 4'hB});
    vecs.push_back('{9'h000, 9'h000, 1'b1, 1'b0, 8'h45, 6, 9'h1FF, 1'b0, 1'b0, 7'h7F, 4'h7});
    vecs.push_back('{9'h1C0, 9'h080, 1'b0, 1'b0, 8'h00, 12, 9'h1C0, 1'b0, 1'b0, 7'h7F, 4'hB});

    reset   = 1'b1;
    occ_pos = 9'h003;
    own_o   = 9'h002;
    turnX   = 1'b1;
    turnO   = 1'b0;
    game_st = 8'h00;

    // Reset held for three clocks; outputs stay at reset values throughout.
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_reset($sformatf("rst_hold%0d", i));
    end

    // Table vectors: each starts from a fresh reset, then N edges.
    for (int i = 0; i < vecs.size(); i++) begin
      occ_pos = vecs[i].occ;
      own_o   = vecs[i].own;
      turnX   = vecs[i].tx;
      turnO   = vecs[i].to;
      game_st = vecs[i].gst;
      reset   = 1'b1;
      step(1);
      check_reset($sformatf("v%0d.rst", i));
      reset = 1'b0;
      step(vecs[i].n);
      check_all($sformatf("v%0d", i), vecs[i].eled, vecs[i].etx, vecs[i].eto,
                vecs[i].eseg, vecs[i].ean);
    end

    // First flash-phase toggle lands exactly 4 clocks after release.
    occ_pos = 9'h002;
    own_o   = 9'h002;
    turnX   = 1'b0;
    turnO   = 1'b0;
    game_st = 8'h00;
    reset   = 1'b1;
    step(1);
    reset = 1'b0;
    step(3);
    check("flash_pre", 32'(led), 32'h000);
    step(1);
    check("flash_first", 32'(led), 32'h002);
    step(4);
    check("flash_second", 32'(led), 32'h000);

    // Mid-slot mode changes with 1-clock latency, then mid-slot reset.
    occ_pos = 9'h000;
    own_o   = 9'h000;
    turnX   = 1'b1;
    reset   = 1'b1;
    step(1);
    reset = 1'b0;
    step(6);                       // N=6: digit 3, PLAY, mover X
    check_all("seq.play", 9'h000, 1'b1, 1'b0, 7'h09, 4'h7);
    game_st = 8'h43;
    step(1);                       // N=7: OVER, digit 3 blanks, turn LEDs off
    check_all("seq.over", 9'h000, 1'b0, 1'b0, 7'h7F, 4'h7);
    game_st = 8'h00;
    step(1);                       // N=8: back to PLAY, digit 0 blank
    check_all("seq.replay", 9'h000, 1'b1, 1'b0, 7'h7F, 4'hE);
    game_st = 8'h45;
    step(1);                       // N=9: ERROR, digit 0 shows E, phase 0
    check_all("seq.err", 9'h000, 1'b0, 1'b0, 7'h06, 4'hE);
    step(3);                       // N=12: phase 1, digit 2
    check_all("seq.errflash", 9'h1FF, 1'b0, 1'b0, 7'h7F, 4'hB);
    game_st = 8'h00;
    step(1);                       // N=13: PLAY again, phase 1, digit 2
    check_all("seq.errexit", 9'h000, 1'b1, 1'b0, 7'h7F, 4'hB);
    reset = 1'b1;
    step(1);
    check_reset("seq.midrst");
    reset = 1'b0;
    step(1);                       // counters restart from zero
    check_all("seq.post", 9'h000, 1'b1, 1'b0, 7'h7F, 4'hE);
    step(5);                       // N=6: digit 3 again
    check_all("seq.post6", 9'h000, 1'b1, 1'b0, 7'h09, 4'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
